// File: rtl/unary_add_pkg.sv
// -----------------------------------------------------------------------------
// unary_add_pkg
// Shared definitions for the unary adder host controller: the controller state
// encoding, the default operand/result width and the length of the adder clear.
// -----------------------------------------------------------------------------
package unary_add_pkg;

    localparam int UA_W         = 6;
    localparam int CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_READ   = 3'd4,
        ST_DONE   = 3'd5
    } uah_state_t;

endpackage

// File: rtl/unary_add_host_if.sv
// -----------------------------------------------------------------------------
// unary_add_host_if
// Binary command/result channel between a command source and the unary adder
// host.
//   in_valid/in_ready : operand pair handshake (source -> host)
//   opa/opb           : unsigned operands
//   res_valid         : one-cycle result strobe (host -> source)
//   res/ovf           : decoded sum and overflow flag
// Modports: master = command source, slave = host controller.
// -----------------------------------------------------------------------------
interface unary_add_host_if
    import unary_add_pkg::*;
#(
    parameter int W = UA_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         res_valid;
    logic [W-1:0] res;
    logic         ovf;

    modport master (
        output in_valid, opa, opb,
        input  in_ready, res_valid, res, ovf
    );

    modport slave (
        input  in_valid, opa, opb,
        output in_ready, res_valid, res, ovf
    );

endinterface

// File: rtl/unary_stream_rx.sv
// -----------------------------------------------------------------------------
// unary_stream_rx
// Run-length decoder for the adder's unary readout.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : high for the whole readout window, low re-arms the decoder
//   dout       : unary readout bit from the adder
//   done       : this cycle's sample ends the readout (a zero, or the cap)
//   len        : ones counted including this cycle's sample, valid with done
// The first cycle of a window is the adder's readout latency and is ignored.
// The count saturates at 2^W-1 so a stuck-high dout still terminates.
// -----------------------------------------------------------------------------
module unary_stream_rx
    import unary_add_pkg::*;
#(
    parameter int W = UA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dout,
    output logic         done,
    output logic [W-1:0] len
);

    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] LEN_CAP = {W{1'b1}};

    logic         r_skip;
    logic [W-1:0] r_len;
    logic         w_sample;

    // A sample counts only inside the window and after the latency cycle.
    assign w_sample = start && !r_skip;

    // Latency-skip flag and ones counter, re-armed whenever the window is closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip <= 1'b1;
            r_len  <= {W{1'b0}};
        end else if (!start) begin
            r_skip <= 1'b1;
            r_len  <= {W{1'b0}};
        end else if (r_skip) begin
            r_skip <= 1'b0;
            r_len  <= r_len;
        end else if (dout && (r_len != LEN_CAP)) begin
            r_skip <= 1'b0;
            r_len  <= r_len + ONE;
        end else begin
            r_skip <= 1'b0;
            r_len  <= r_len;
        end
    end

    // Termination: a zero sample, or the one that brings the count to the cap.
    always_comb begin
        done = w_sample && (!dout || (r_len == (LEN_CAP - ONE)));
        len  = (w_sample && dout) ? (r_len + ONE) : r_len;
    end

endmodule

// File: rtl/unary_add_host.sv
// -----------------------------------------------------------------------------
// unary_add_host
// Host controller for a unary adder: accepts a binary operand pair, clears the
// adder, writes both operands as paired pulse trains, reads the unary count back
// and returns it as a binary sum with an overflow flag.
//   clk, rst_n     : clock, asynchronous active-low reset
//   cmd (slave)    : in_valid/in_ready/opa/opb in, res_valid/res/ovf out
//   add_rst_n      : adder reset (active-low)
//   en             : adder enable
//   read_or_write  : 0 = accumulate, 1 = unary readout
//   A, B           : pulse lines to the adder
//   dout, C        : adder readout bit and carry/overflow
// Every output is a flop loaded from the next-state decode, so outputs change
// in step with the state and nothing from dout/C reaches a pin combinationally.
// -----------------------------------------------------------------------------
module unary_add_host
    import unary_add_pkg::*;
#(
    parameter int W = UA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    unary_add_host_if.slave    cmd,
    output logic               add_rst_n,
    output logic               en,
    output logic               read_or_write,
    output logic               A,
    output logic               B,
    input  logic               dout,
    input  logic               C
);

    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [1:0]   CLR_LAST = 2'(CLEAR_CYCLES - 1);

    uah_state_t   r_state, w_next_state;
    logic [W-1:0] r_opa, r_opb, r_n;
    logic [W-1:0] r_idx, w_next_idx;
    logic         r_phase, w_next_phase;      // 0 = pulse cycle, 1 = gap cycle
    logic [1:0]   r_clr, w_next_clr;
    logic         r_ovf_sticky;

    logic         r_in_ready, r_add_rst_n, r_en, r_rw, r_a, r_b;
    logic         r_res_valid, r_ovf;
    logic [W-1:0] r_res;

    logic         w_accept;
    logic         w_rx_start, w_rx_done;
    logic [W-1:0] w_rx_len;
    logic         w_pulse;

    // Accept only when the registered ready is up, so the cycle right after
    // reset release cannot take a command.
    assign w_accept   = (r_state == ST_IDLE) && r_in_ready && cmd.in_valid;
    assign w_rx_start = (r_state == ST_READ);

    unary_stream_rx #(.W(W)) u_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_rx_start),
        .dout  (dout),
        .done  (w_rx_done),
        .len   (w_rx_len)
    );

    // Next-state and pulse-sequencing counters.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_phase = r_phase;
        w_next_clr   = r_clr;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_CLEAR;
                    w_next_clr   = 2'd0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (r_clr == CLR_LAST) begin
                    w_next_idx   = {W{1'b0}};
                    w_next_phase = 1'b0;
                    w_next_state = (r_n == {W{1'b0}}) ? ST_SETTLE : ST_WRITE;
                end else begin
                    w_next_clr   = r_clr + 2'd1;
                end
            end
            ST_WRITE: begin
                if (!r_phase) begin
                    w_next_phase = 1'b1;
                end else if (r_idx == (r_n - ONE)) begin
                    w_next_state = ST_SETTLE;
                end else begin
                    w_next_idx   = r_idx + ONE;
                    w_next_phase = 1'b0;
                end
            end
            ST_SETTLE: w_next_state = ST_READ;
            ST_READ: begin
                if (w_rx_done) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_READ;
                end
            end
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // A pulse cycle drives each line while its operand still has pulses left.
    assign w_pulse = (w_next_state == ST_WRITE) && !w_next_phase;

    // State, operand latches, counters and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_opa        <= {W{1'b0}};
            r_opb        <= {W{1'b0}};
            r_n          <= {W{1'b0}};
            r_idx        <= {W{1'b0}};
            r_phase      <= 1'b0;
            r_clr        <= 2'd0;
            r_ovf_sticky <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_phase <= w_next_phase;
            r_clr   <= w_next_clr;
            if (w_accept) begin
                r_opa        <= cmd.opa;
                r_opb        <= cmd.opb;
                r_n          <= (cmd.opa > cmd.opb) ? cmd.opa : cmd.opb;
                r_ovf_sticky <= 1'b0;
            end else if ((r_state == ST_WRITE) || (r_state == ST_SETTLE)) begin
                r_ovf_sticky <= r_ovf_sticky | C;
            end else begin
                r_ovf_sticky <= r_ovf_sticky;
            end
        end
    end

    // Output flops decoded from the next state; result fields load on DONE only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_add_rst_n <= 1'b0;
            r_en        <= 1'b0;
            r_rw        <= 1'b0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_res_valid <= 1'b0;
            r_res       <= {W{1'b0}};
            r_ovf       <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == ST_IDLE);
            r_add_rst_n <= (w_next_state != ST_CLEAR);
            r_en        <= (w_next_state == ST_WRITE) || (w_next_state == ST_SETTLE) ||
                           (w_next_state == ST_READ);
            r_rw        <= (w_next_state == ST_READ);
            r_a         <= w_pulse && (w_next_idx < r_opa);
            r_b         <= w_pulse && (w_next_idx < r_opb);
            r_res_valid <= (w_next_state == ST_DONE);
            if (w_next_state == ST_DONE) begin
                r_res <= w_rx_len;
                r_ovf <= r_ovf_sticky;
            end else begin
                r_res <= r_res;
                r_ovf <= r_ovf;
            end
        end
    end

    assign cmd.in_ready  = r_in_ready;
    assign cmd.res_valid = r_res_valid;
    assign cmd.res       = r_res;
    assign cmd.ovf       = r_ovf;
    assign add_rst_n     = r_add_rst_n;
    assign en            = r_en;
    assign read_or_write = r_rw;
    assign A             = r_a;
    assign B             = r_b;

endmodule
